// File: rtl/cache_pkg.sv
// Shared types and address helpers for the direct-mapped refill cache.
// State encoding plus tag/index extraction used by controller and store.
package cache_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE     = 3'd0;
  localparam state_t LOOKUP   = 3'd1;
  localparam state_t MEM_REQ  = 3'd2;
  localparam state_t MEM_WAIT = 3'd3;
  localparam state_t FILL     = 3'd4;

  function automatic int tag_w(
    input int addr_w,
    input int index_w
  );
    return addr_w - index_w - 2;
  endfunction

  function automatic logic [63:0] addr_index(
    input logic [63:0] addr,
    input int          index_w
  );
    return (addr >> 2) & ((64'd1 << index_w) - 64'd1);
  endfunction

  function automatic logic [63:0] addr_tag(
    input logic [63:0] addr,
    input int          index_w
  );
    return addr >> (index_w + 2);
  endfunction

endpackage

// File: rtl/cache_line_store.sv
// Tag/data arrays with combinational read and a clearable valid vector.
// Arrays keep contents across reset; only the valid bits are cleared.
module cache_line_store
  import cache_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [DATA_W-1:0]  wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_data;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/cache_refill_controller.sv
// Direct-mapped one-word-per-line cache: lookup FSM and refill handshake.
// Hits answer one cycle after acceptance; misses refill via a single read.
module cache_refill_controller
  import cache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              hit,
  output logic              miss,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  input  logic              flush
);

  localparam int TAG_W = tag_w(ADDR_W, INDEX_W);

  state_t             state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  resp_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [DATA_W-1:0]  rd_data;
  logic               tag_match;
  logic               st_idle;
  logic               st_lookup;
  logic               wr_en;
  logic               clear;

  assign idx = INDEX_W'(addr_index(64'(addr_q), INDEX_W));
  assign tag = TAG_W'(addr_tag(64'(addr_q), INDEX_W));

  assign st_idle   = (state_q == IDLE);
  assign st_lookup = (state_q == LOOKUP);
  assign tag_match = rd_valid && (rd_tag == tag);

  assign clear = st_idle && flush;
  assign wr_en = (state_q == MEM_WAIT) && mem_resp_valid && !reset;

  cache_line_store #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W),
    .DATA_W  (DATA_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .rd_index (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_index (idx),
    .wr_tag   (tag),
    .wr_data  (mem_resp_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      resp_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!flush && req_valid) begin
            addr_q  <= req_addr;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (tag_match) begin
            resp_q  <= rd_data;
            state_q <= IDLE;
          end else begin
            state_q <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_req_ready) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            resp_q  <= mem_resp_data;
            state_q <= FILL;
          end
        end
        FILL: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // resp_q holds the last returned word so resp_data is stable between pulses
  assign req_ready     = st_idle;
  assign hit           = st_lookup && tag_match;
  assign resp_valid    = hit || (state_q == FILL);
  assign resp_data     = hit ? rd_data : resp_q;
  assign miss          = (st_lookup && !tag_match)
                       || (state_q == MEM_REQ)
                       || (state_q == MEM_WAIT);
  assign mem_req_valid = (state_q == MEM_REQ);
  assign mem_req_addr  = {addr_q[ADDR_W-1:2], 2'b00};

endmodule

// File: tb/tb_cache_refill_controller.sv
// Directed bench for cache_refill_controller with immediate assertions.
// Hit, miss, eviction, stall, flush, reset-abort and alignment cases.
module tb_cache_refill_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        hit;
  logic        miss;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        flush = 1'b0;

  int nvec = 0;
  int nerr = 0;

  cache_refill_controller #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .INDEX_W (6)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_addr       (req_addr),
    .req_ready      (req_ready),
    .resp_valid     (resp_valid),
    .resp_data      (resp_data),
    .hit            (hit),
    .miss           (miss),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic read_hit(input logic [31:0] addr, input logic [31:0] exp);
    chk("hit_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    chk("hit_rv", 32'(resp_valid), 32'd1);
    chk("hit_flag", 32'(hit), 32'd1);
    chk("hit_data", resp_data, exp);
    chk("hit_nomem", 32'(mem_req_valid), 32'd0);
    chk("hit_miss", 32'(miss), 32'd0);
    step();
    chk("hit_done_rv", 32'(resp_valid), 32'd0);
    chk("hit_done_ready", 32'(req_ready), 32'd1);
    chk("hit_hold_data", resp_data, exp);
  endtask

  task automatic read_miss(input logic [31:0] addr, input logic [31:0] maddr,
                           input logic [31:0] data, input int rqd,
                           input int rsd);
    req_valid = 1'b1;
    req_addr  = addr;
    step();
    req_valid = 1'b0;
    chk("lk_miss", 32'(miss), 32'd1);
    chk("lk_rv", 32'(resp_valid), 32'd0);
    chk("lk_hit", 32'(hit), 32'd0);
    chk("lk_ready", 32'(req_ready), 32'd0);
    step();
    for (int i = 0; i < rqd; i++) begin
      chk("mr_valid", 32'(mem_req_valid), 32'd1);
      chk("mr_addr", mem_req_addr, maddr);
      chk("mr_miss", 32'(miss), 32'd1);
      step();
    end
    chk("mr_valid", 32'(mem_req_valid), 32'd1);
    chk("mr_addr", mem_req_addr, maddr);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("mw_reqdrop", 32'(mem_req_valid), 32'd0);
    for (int i = 0; i < rsd; i++) begin
      chk("mw_miss", 32'(miss), 32'd1);
      chk("mw_rv", 32'(resp_valid), 32'd0);
      chk("mw_noreq", 32'(mem_req_valid), 32'd0);
      step();
    end
    chk("mw_miss", 32'(miss), 32'd1);
    mem_resp_valid = 1'b1;
    mem_resp_data  = data;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    chk("fill_rv", 32'(resp_valid), 32'd1);
    chk("fill_hit", 32'(hit), 32'd0);
    chk("fill_data", resp_data, data);
    chk("fill_miss", 32'(miss), 32'd0);
    step();
    chk("fill_done_rv", 32'(resp_valid), 32'd0);
    chk("fill_done_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    // reset
    reset = 1'b1;
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rv", 32'(resp_valid), 32'd0);
    chk("rst_hit", 32'(hit), 32'd0);
    chk("rst_miss", 32'(miss), 32'd0);
    chk("rst_mrv", 32'(mem_req_valid), 32'd0);
    chk("rst_data", resp_data, 32'h0);
    chk("rst_maddr", mem_req_addr, 32'h0);
    reset = 1'b0;
    step();

    // cold miss then hit
    read_miss(32'h100, 32'h100, 32'hDEADBEEF, 0, 0);
    read_hit(32'h100, 32'hDEADBEEF);

    // conflict eviction on index 0
    read_miss(32'h200, 32'h200, 32'h22222222, 0, 0);
    read_hit(32'h200, 32'h22222222);
    read_miss(32'h100, 32'h100, 32'h11111111, 0, 0);
    read_hit(32'h100, 32'h11111111);
    read_miss(32'h200, 32'h200, 32'h22222222, 0, 0);

    // stalled request and delayed response
    read_miss(32'h300, 32'h300, 32'h33333333, 5, 4);
    read_hit(32'h300, 32'h33333333);

    // flush wins over same-cycle request
    read_miss(32'h40, 32'h40, 32'h44444444, 0, 0);
    read_hit(32'h40, 32'h44444444);
    req_valid = 1'b1;
    req_addr  = 32'h40;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    chk("fl_ready", 32'(req_ready), 32'd1);
    chk("fl_rv", 32'(resp_valid), 32'd0);
    chk("fl_miss", 32'(miss), 32'd0);
    step();
    chk("fl_idle", 32'(req_ready), 32'd1);
    chk("fl_nomem", 32'(mem_req_valid), 32'd0);
    read_miss(32'h40, 32'h40, 32'h44444444, 0, 0);
    read_miss(32'h300, 32'h300, 32'h33333333, 0, 0);

    // reset during MEM_WAIT, then a late response
    req_valid = 1'b1;
    req_addr  = 32'h500;
    step();
    req_valid = 1'b0;
    step();
    chk("ra_mrv", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    chk("ra_wait", 32'(miss), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("ra_ready", 32'(req_ready), 32'd1);
    chk("ra_miss", 32'(miss), 32'd0);
    chk("ra_mrv0", 32'(mem_req_valid), 32'd0);
    chk("ra_maddr", mem_req_addr, 32'h0);
    chk("ra_data", resp_data, 32'h0);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hBADBAD00;
    step();
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    chk("ra_late_rv", 32'(resp_valid), 32'd0);
    chk("ra_late_ready", 32'(req_ready), 32'd1);
    chk("ra_late_data", resp_data, 32'h0);
    step();
    chk("ra_quiet", 32'(resp_valid), 32'd0);
    read_miss(32'h500, 32'h500, 32'h55555555, 0, 0);
    read_miss(32'h300, 32'h300, 32'h33333333, 0, 0);

    // byte offset bits ignored
    read_miss(32'h103, 32'h100, 32'h66666666, 1, 2);
    read_hit(32'h100, 32'h66666666);
    read_hit(32'h101, 32'h66666666);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
